// File: rtl/lcd_pkg.sv
// Shared types and constants for the character-LCD bus blocks.
// Imported by the arbiter, its interface users and the bench.
package lcd_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WSET,
      WEN,
      WHOLD,
      PSET,
      PEN,
      PSAMP,
      DONE
   } state_t;

   localparam logic [7:0] CLEAR        = 8'h01;
   localparam logic [7:0] HOME         = 8'h02;
   localparam logic [7:0] ENTRY        = 8'h06;
   localparam logic [7:0] DISP_ON      = 8'h0C;
   localparam logic [7:0] FUNC_8BIT_2L = 8'h38;

   localparam int BUSY_BIT = 7;

endpackage

// File: rtl/lcd_bus_arbiter_if.sv
// Requester handshakes plus the LCD control/status lines.
// The 8-bit data bus stays a plain inout on the arbiter.
interface lcd_bus_arbiter_if;

   logic       req0;
   logic       rs0;
   logic [7:0] data0;
   logic       ack0;
   logic       req1;
   logic       rs1;
   logic [7:0] data1;
   logic       ack1;
   logic       E;
   logic       RS;
   logic       RW;
   logic       busy;
   logic       err;

   modport master (
      output req0, rs0, data0, req1, rs1, data1,
      input  ack0, ack1, E, RS, RW, busy, err
   );

   modport slave (
      input  req0, rs0, data0, req1, rs1, data1,
      output ack0, ack1, E, RS, RW, busy, err
   );

endinterface

// File: rtl/lcd_tick_gen.sv
// Free-running prescaler producing one tick per 2**PRESC_W clocks.
// Tick is high while the count is all ones.
module lcd_tick_gen #(
   parameter int PRESC_W = 8
) (
   input  logic CLK,
   input  logic RSTn,
   output logic tick
);

   logic [PRESC_W-1:0] cnt;

   // wrapping prescaler count
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) cnt <= '0;
      else       cnt <= cnt + PRESC_W'(1);
   end

   assign tick = &cnt;

endmodule

// File: rtl/lcd_bus_arbiter.sv
// Round-robin owner of one HD44780-style bus: write cycle,
// then busy-flag polling, then a one-cycle ack to the winner.
module lcd_bus_arbiter
   import lcd_pkg::*;
#(
   parameter int PRESC_W  = 8,
   parameter int MAX_POLL = 64
) (
   input  logic             CLK,
   input  logic             RSTn,
   lcd_bus_arbiter_if.slave bus,
   inout  wire  [7:0]       DB
);

   localparam int PW = (MAX_POLL > 1) ? $clog2(MAX_POLL) : 1;

   state_t        state;
   state_t        state_n;
   logic          tick;
   logic          take;
   logic          win;
   logic          busy_rd;
   logic          poll_last;
   logic          drive;
   logic          rs_q;
   logic          last_grant;
   logic          err_q;
   logic [7:0]    data_q;
   logic [PW-1:0] poll_cnt;

   lcd_tick_gen #(
      .PRESC_W(PRESC_W)
   ) u_tick (
      .CLK (CLK),
      .RSTn(RSTn),
      .tick(tick)
   );

   assign busy_rd   = DB[BUSY_BIT];
   assign poll_last = (poll_cnt == PW'(MAX_POLL - 1));
   assign win       = (bus.req0 && bus.req1) ? ~last_grant : bus.req1;

   // state register
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) state <= IDLE;
      else       state <= state_n;
   end

   // next state: grant is immediate, bus phases wait for tick
   always_comb begin
      state_n = state;
      take    = 1'b0;
      unique case (state)
         IDLE: begin
            if (bus.req0 || bus.req1) begin
               take    = 1'b1;
               state_n = WSET;
            end
         end
         WSET:  if (tick) state_n = WEN;
         WEN:   if (tick) state_n = WHOLD;
         WHOLD: if (tick) state_n = PSET;
         PSET:  if (tick) state_n = PEN;
         PEN:   if (tick) state_n = PSAMP;
         PSAMP: begin
            if (tick) state_n = (busy_rd && !poll_last) ? PSET : DONE;
         end
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // request capture, round-robin memory, poll count, sticky error
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         rs_q       <= 1'b0;
         data_q     <= '0;
         last_grant <= 1'b1;
         poll_cnt   <= '0;
         err_q      <= 1'b0;
      end else if (take) begin
         rs_q       <= win ? bus.rs1 : bus.rs0;
         data_q     <= win ? bus.data1 : bus.data0;
         last_grant <= win;
         poll_cnt   <= '0;
      end else if (state == PSAMP && tick && busy_rd) begin
         if (poll_last) err_q    <= 1'b1;
         else           poll_cnt <= poll_cnt + PW'(1);
      end
   end

   // bus pins and acks decoded from state alone
   always_comb begin
      bus.E    = 1'b0;
      bus.RS   = 1'b0;
      bus.RW   = 1'b1;
      bus.ack0 = 1'b0;
      bus.ack1 = 1'b0;
      drive    = 1'b0;
      unique case (state)
         WSET, WHOLD: begin
            bus.RW = 1'b0;
            bus.RS = rs_q;
            drive  = 1'b1;
         end
         WEN: begin
            bus.E  = 1'b1;
            bus.RW = 1'b0;
            bus.RS = rs_q;
            drive  = 1'b1;
         end
         PEN, PSAMP: bus.E = 1'b1;
         DONE: begin
            bus.ack0 = ~last_grant;
            bus.ack1 = last_grant;
         end
         default: ;
      endcase
   end

   assign bus.busy = (state != IDLE);
   assign bus.err  = err_q;
   assign DB       = drive ? data_q : 8'hzz;

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// Bench for lcd_bus_arbiter: vector table, corner sequences,
// random transactions against a transaction-level model.
module tb_lcd_bus_arbiter;
   import lcd_pkg::*;

   localparam int PRESC_W  = 2;
   localparam int MAX_POLL = 4;
   localparam int TICK     = 1 << PRESC_W;

   typedef struct {
      bit       r0;
      bit       r1;
      bit       s0;
      bit [7:0] d0;
      bit       s1;
      bit [7:0] d1;
      int       br;
      int       ew;
      bit       ers;
      bit [7:0] ed;
      int       ep;
      bit       ee;
   } vec_t;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   wire  [7:0] DB;
   int         lcd_busy = 0;
   logic [7:0] lcd_val;

   int total = 0;
   int bad   = 0;
   int model_last = 1;
   int model_err  = 0;
   vec_t tbl [10];

   int         cyc = 0;
   int         wr_pulses = 0;
   int         poll_pulses = 0;
   int         width_viol = 0;
   int         hold_viol = 0;
   int         ack0_n = 0;
   int         ack1_n = 0;
   int         rise_cyc = 0;
   int         ack_cyc = 0;
   int         bus_viol = 0;
   int         ev_viol = 0;
   int         both_viol = 0;
   int         e_len = 0;
   logic       e_prev = 1'b0;
   logic       rw_prev = 1'b1;
   logic       rs_prev = 1'b0;
   logic       rd_pulse = 1'b0;
   logic       wr_rs = 1'b0;
   logic [7:0] wr_data = 8'h00;

   lcd_bus_arbiter_if bus ();

   lcd_bus_arbiter #(
      .PRESC_W (PRESC_W),
      .MAX_POLL(MAX_POLL)
   ) dut (
      .CLK (clk),
      .RSTn(rst_n),
      .bus (bus),
      .DB  (DB)
   );

   always #5 clk = ~clk;

   // LCD model: answers reads with its busy flag, never drives on writes
   assign lcd_val = {lcd_busy != 0, 7'h00};
   assign DB      = bus.RW ? lcd_val : 8'hzz;

   initial begin
      #1ms;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   // bus observer sampling on the falling edge
   always @(negedge clk) begin
      cyc = cyc + 1;
      if (bus.E && !e_prev) begin
         e_len    = 0;
         rd_pulse = bus.RW;
         if (bus.RW != rw_prev || bus.RS != rs_prev) ev_viol++;
         if (!bus.RW) begin
            wr_pulses++;
            wr_rs    = bus.RS;
            wr_data  = DB;
            rise_cyc = cyc;
         end else begin
            poll_pulses++;
         end
      end
      if (bus.E) begin
         e_len++;
         if (!bus.RW && (DB != wr_data || bus.RS != wr_rs)) hold_viol++;
      end
      if (!bus.E && e_prev) begin
         if (e_len != (rd_pulse ? 2 * TICK : TICK)) width_viol++;
         if (!rd_pulse && (bus.RW || DB != wr_data)) hold_viol++;
         if (rd_pulse && lcd_busy > 0) lcd_busy--;
      end
      if (bus.ack0) begin ack0_n++; ack_cyc = cyc; end
      if (bus.ack1) begin ack1_n++; ack_cyc = cyc; end
      if (bus.ack0 && bus.ack1) both_viol++;
      if (bus.RW && DB != lcd_val) bus_viol++;
      e_prev  = bus.E;
      rw_prev = bus.RW;
      rs_prev = bus.RS;
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic check(input string name, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)",
                  name, got, got, exp, exp);
      end
   endtask

   task automatic clr_mon();
      wr_pulses   = 0;
      poll_pulses = 0;
      width_viol  = 0;
      hold_viol   = 0;
      ack0_n      = 0;
      ack1_n      = 0;
   endtask

   task automatic wait_ack(input string tag);
      int n = 0;
      while (!(bus.ack0 || bus.ack1) && n < 400) begin
         step();
         n++;
      end
      check({tag, " ack seen"}, int'(bus.ack0 || bus.ack1), 1);
   endtask

   task automatic run_txn(input string tag, input vec_t v);
      step();
      lcd_busy  = v.br;
      clr_mon();
      bus.req0  = v.r0;
      bus.req1  = v.r1;
      bus.rs0   = v.s0;
      bus.data0 = v.d0;
      bus.rs1   = v.s1;
      bus.data1 = v.d1;
      wait_ack(tag);
      check({tag, " busy at ack"}, int'(bus.busy), 1);
      bus.req0 = 1'b0;
      bus.req1 = 1'b0;
      step();
      step();
      check({tag, " busy after"}, int'(bus.busy), 0);
      check({tag, " ack0 count"}, ack0_n, int'(v.ew == 0));
      check({tag, " ack1 count"}, ack1_n, int'(v.ew == 1));
      check({tag, " write pulses"}, wr_pulses, 1);
      check({tag, " RS"}, int'(wr_rs), int'(v.ers));
      check({tag, " DB"}, int'(wr_data), int'(v.ed));
      check({tag, " polls"}, poll_pulses, v.ep);
      check({tag, " E width"}, width_viol, 0);
      check({tag, " hold"}, hold_viol, 0);
      check({tag, " rise to ack"}, ack_cyc - rise_cyc,
            TICK * (5 + 3 * (v.ep - 1)));
      check({tag, " err"}, int'(bus.err), int'(v.ee));
   endtask

   initial begin
      int   n;
      int   w;
      vec_t v;

      bus.req0  = 1'b0;
      bus.req1  = 1'b0;
      bus.rs0   = 1'b0;
      bus.rs1   = 1'b0;
      bus.data0 = 8'h00;
      bus.data1 = 8'h00;
      step();
      step();
      check("reset E", int'(bus.E), 0);
      check("reset RS", int'(bus.RS), 0);
      check("reset RW", int'(bus.RW), 1);
      check("reset busy", int'(bus.busy), 0);
      check("reset err", int'(bus.err), 0);
      check("reset acks", int'({bus.ack0, bus.ack1}), 0);
      check("reset DB released", int'(DB), int'(lcd_val));
      rst_n = 1'b1;
      step();

      tbl[0] = '{1, 1, 0, CLEAR, 0, FUNC_8BIT_2L, 0, 0, 0, CLEAR, 1, 0};
      tbl[1] = '{1, 1, 0, CLEAR, 0, FUNC_8BIT_2L, 0, 1, 0, FUNC_8BIT_2L, 1, 0};
      tbl[2] = '{1, 1, 0, CLEAR, 0, FUNC_8BIT_2L, 0, 0, 0, CLEAR, 1, 0};
      tbl[3] = '{1, 1, 0, CLEAR, 0, FUNC_8BIT_2L, 0, 1, 0, FUNC_8BIT_2L, 1, 0};
      tbl[4] = '{1, 0, 1, 8'h48, 0, 8'h00, 0, 0, 1, 8'h48, 1, 0};
      tbl[5] = '{0, 1, 0, 8'h00, 1, 8'h41, 3, 1, 1, 8'h41, 4, 0};
      tbl[6] = '{1, 0, 0, DISP_ON, 0, 8'h00, 7, 0, 0, DISP_ON, 4, 1};
      tbl[7] = '{1, 1, 0, ENTRY, 0, HOME, 0, 1, 0, HOME, 1, 1};
      tbl[8] = '{0, 1, 0, 8'h00, 1, 8'h5A, 1, 1, 1, 8'h5A, 2, 1};
      tbl[9] = '{1, 1, 0, CLEAR, 0, FUNC_8BIT_2L, 2, 0, 0, CLEAR, 3, 1};

      for (int i = 0; i < 10; i++) begin
         run_txn($sformatf("vec%0d", i), tbl[i]);
         model_last = tbl[i].ew;
         model_err  = int'(tbl[i].ee);
      end

      // req1 pulse that ends before the arbiter is idle again
      step();
      lcd_busy  = 0;
      clr_mon();
      bus.req0  = 1'b1;
      bus.rs0   = 1'b0;
      bus.data0 = DISP_ON;
      n = 0;
      while (!bus.busy && n < 50) begin step(); n++; end
      bus.req1  = 1'b1;
      bus.rs1   = 1'b1;
      bus.data1 = 8'h55;
      step();
      step();
      bus.req1 = 1'b0;
      wait_ack("pulse");
      bus.req0 = 1'b0;
      repeat (10) step();
      check("pulse ack1 count", ack1_n, 0);
      check("pulse ack0 count", ack0_n, 1);
      check("pulse busy", int'(bus.busy), 0);
      check("pulse DB", int'(wr_data), int'(DISP_ON));
      model_last = 0;

      // loser keeps requesting across the winner's ack
      step();
      clr_mon();
      w = 1 - model_last;
      bus.req0  = 1'b1;
      bus.req1  = 1'b1;
      bus.rs0   = 1'b0;
      bus.rs1   = 1'b0;
      bus.data0 = ENTRY;
      bus.data1 = HOME;
      wait_ack("b2b first");
      check("b2b first winner", int'(bus.ack1), w);
      if (w == 1) bus.req1 = 1'b0;
      else        bus.req0 = 1'b0;
      step();
      wait_ack("b2b second");
      check("b2b second winner", int'(bus.ack1), 1 - w);
      bus.req0 = 1'b0;
      bus.req1 = 1'b0;
      step();
      check("b2b writes", wr_pulses, 2);
      check("b2b last DB", int'(wr_data),
            int'((w == 1) ? ENTRY : HOME));
      model_last = 1 - w;

      // asynchronous reset while polling
      step();
      clr_mon();
      lcd_busy  = 3;
      bus.req0  = 1'b1;
      bus.rs0   = 1'b1;
      bus.data0 = 8'h48;
      n = 0;
      while (!(bus.E && bus.RW) && n < 200) begin step(); n++; end
      check("rst reached PEN", int'(bus.E && bus.RW), 1);
      rst_n = 1'b0;
      #1;
      check("rst E", int'(bus.E), 0);
      check("rst RW", int'(bus.RW), 1);
      check("rst RS", int'(bus.RS), 0);
      check("rst DB released", int'(DB), int'(lcd_val));
      check("rst busy", int'(bus.busy), 0);
      check("rst ack0", int'(bus.ack0), 0);
      bus.req0  = 1'b0;
      bus.req1  = 1'b1;
      bus.rs1   = 1'b0;
      bus.data1 = HOME;
      step();
      step();
      rst_n    = 1'b1;
      lcd_busy = 0;
      check("rst release busy", int'(bus.busy), 0);
      check("rst clears err", int'(bus.err), 0);
      wait_ack("rst req1");
      check("rst req1 winner", int'(bus.ack1), 1);
      bus.req1 = 1'b0;
      step();
      step();
      check("rst no ack0", ack0_n, 0);
      check("rst one ack1", ack1_n, 1);
      check("rst req1 DB", int'(wr_data), int'(HOME));
      model_last = 1;
      model_err  = 0;

      // random transactions against the transaction-level model
      for (int k = 0; k < 12; k++) begin
         int pat;
         pat  = int'($urandom_range(1, 3));
         v.r0 = pat[0];
         v.r1 = pat[1];
         v.s0 = 1'($urandom_range(0, 1));
         v.s1 = 1'($urandom_range(0, 1));
         v.d0 = 8'($urandom_range(0, 255));
         v.d1 = 8'($urandom_range(0, 255));
         v.br = int'($urandom_range(0, 5));
         if (v.r0 && v.r1) v.ew = 1 - model_last;
         else              v.ew = v.r1 ? 1 : 0;
         v.ers = (v.ew == 1) ? v.s1 : v.s0;
         v.ed  = (v.ew == 1) ? v.d1 : v.d0;
         v.ep  = (v.br + 1 < MAX_POLL) ? v.br + 1 : MAX_POLL;
         if (v.br >= MAX_POLL) model_err = 1;
         v.ee = 1'(model_err);
         run_txn($sformatf("rnd%0d", k), v);
         model_last = v.ew;
      end

      check("DB driven while RW=1", bus_viol, 0);
      check("E rise with RS/RW change", ev_viol, 0);
      check("both acks high", both_viol, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/lcd_bus_arbiter.md
Name: lcd_bus_arbiter

Overview:
- Shares one HD44780-style character-LCD bus (E, RS, RW, 8-bit bidirectional DB) between two byte-write requesters, e.g. a text-ROM sequencer and a cursor/command generator.
- Each granted request runs one complete bus transaction: a write cycle, then busy-flag polling until the LCD is ready.
- Bus timing comes from a free-running prescaler tick; requesters see a simple req/ack handshake.

Parameters:
- PRESC_W, 8, prescaler width; one tick every 2**PRESC_W CLK cycles.
- MAX_POLL, 64, maximum busy-flag reads per transaction before it is aborted.

Ports:
- CLK  in  1  system clock
- RSTn  in  1  asynchronous active-low reset
- req0  in  1  requester 0 transaction request; level, held until ack0
- rs0  in  1  requester 0 register select: 1 data, 0 command
- data0  in  8  requester 0 byte
- ack0  out  1  one-CLK pulse when requester 0's transaction completes
- req1, rs1, data1, ack1: same as requester 0, for requester 1
- E  out  1  LCD enable
- RS  out  1  LCD register select
- RW  out  1  LCD read/write: 1 read, 0 write
- DB  inout  8  LCD data bus; driven only during write states, high-Z otherwise
- busy  out  1  high from grant until the cycle after ack
- err  out  1  sticky busy-poll timeout flag; cleared only by reset

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low (CLK, RSTn). All registers use it.
- Reset values: E=0, RS=0, RW=1, DB released, ack0=ack1=0, busy=0, err=0, state=IDLE, poll_cnt=0, prescaler=0, last_grant=1 (so requester 0 wins the first tie).
- Tick: prescaler counts 0..2**PRESC_W-1 and wraps. tick=1 in the CLK cycle where the count is all ones.
- IDLE: if no req, stay. Only req0 -> grant 0. Only req1 -> grant 1. Both -> grant the requester not equal to last_grant (round-robin).
- On grant:
  - latch rs/data of the winner into rs_q/data_q; update last_grant;
  - busy<=1; poll_cnt<=0; go to WSET on the next CLK, without waiting for a tick.
- Every remaining state advances only on tick:
  - WSET: RW=0, RS=rs_q, DB=data_q, E=0 -> WEN.
  - WEN: E=1, bus held -> WHOLD.
  - WHOLD: E=0, bus still driven (hold time) -> PSET.
  - PSET: DB released, RW=1, RS=0, E=0 -> PEN.
  - PEN: E=1 -> PSAMP.
  - PSAMP: on tick, sample DB[7] and set E=0.
    - DB[7]=0 -> DONE.
    - DB[7]=1 and poll_cnt<MAX_POLL-1 -> poll_cnt++, PSET.
    - DB[7]=1 and poll_cnt=MAX_POLL-1 -> err<=1, DONE.
  - DONE (one CLK, no tick wait): ack of the granted requester=1, busy<=0 -> IDLE.
- Minimum transaction, one poll: grant + 6 ticks + 1 CLK. Each extra poll adds 3 ticks.
- Requester data is captured at grant, so changes to req/rs/data after grant are ignored.
- Dropping req before grant means no transaction. Dropping req mid-transaction does not abort it; ack is still pulsed.
- A requester still asserting req in the cycle after ack is treated as a new request. Round-robin guarantees the other requester wins any tie.
- The arbiter never drives DB while RW=1. RW goes to 1 in the same cycle DB is released.
- Reset mid-transaction: outputs return to reset values immediately (asynchronous); no ack is generated.
- ack0 and ack1 are never high together. E never rises in the same CLK in which RS or RW changes.

Decomposition:
- Package lcd_pkg:
  - state enumeration (IDLE, WSET, WEN, WHOLD, PSET, PEN, PSAMP, DONE);
  - LCD command constants (CLEAR=8'h01, HOME=8'h02, ENTRY=8'h06, DISP_ON=8'h0C, FUNC_8BIT_2L=8'h38);
  - BUSY_BIT=7.
- Sub-module lcd_tick_gen (parameter PRESC_W; ports CLK, RSTn, tick) for the prescaler. It is reusable by other LCD blocks.

Test Plan:
- PRESC_W=2, LCD model with busy=0; req0=1, rs0=1, data0=8'h48 -> DB=8'h48 with RS=1, RW=0 while E=1; E high for exactly 4 CLK; ack0 pulses once; total time from grant to ack = 1+24+1 CLK.
- req0 and req1 both asserted from reset, each held until its ack, then re-raised -> grant order 0,1,0,1; data0=8'h01 and data1=8'h38 appear alternately on DB.
- LCD model holds DB[7]=1 for 3 reads, then 0 -> exactly 4 E pulses in poll phase; ack after 3+4*3 ticks; err stays 0.
- MAX_POLL=4 with DB[7] stuck at 1 -> 4 poll pulses, then err=1 and ack pulses; next transaction still executes normally and err stays 1.
- Assert RSTn=0 while in PEN -> E=0, RW=1, DB high-Z in the same cycle; no ack; after release, busy=0 and a pending req1 is granted.
- req1 pulsed high then low before IDLE samples it (during another transaction) -> no grant and no ack1; bus checker confirms DB is never driven while RW=1.
